wb_ram_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/wb_arb_watchdog.sv | 35 +++
 rtl/wb_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types, constants and the round-robin selection helper for the
// wb_ram arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Wishbone B3 cycle-type codes seen on the CTI lines.
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Upper bound on the master count; rr_pick works on vectors this wide.
    localparam int MAX_MASTERS = 8;

    // First requester strictly after 'last', wrapping modulo n. If nobody
    // requests, 'last' is returned unchanged (the caller only uses the
    // result when at least one request is present).
    function automatic logic [2:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                           input logic [2:0]             last,
                                           input int                     n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_MASTERS; i++) begin
            idx = (int'(last) + i) % n;
            if (!found && (i <= n) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-access stall watchdog: counts strobe cycles without a slave response
// and raises a one-cycle abort when the wait reaches TIMEOUT cycles.
module wb_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,   // arbiter is in GRANT
    input  logic stb,      // granted master's strobe, before abort masking
    input  logic resp,     // any of ack/err/rty from the slave
    output logic abort
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // A real slave response in the would-be abort cycle takes precedence.
    assign abort = active && stb && !resp && (count == LAST);

    // Wait counter: clears on response, abort or leaving GRANT.
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!active || resp || abort) begin
            count <= '0;
        end else if (stb) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one wb_ram slave between several
// masters. Ownership lasts for the whole bus cycle (cyc high), bursts
// included; a one-cycle IDLE gap separates consecutive owners.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [NUM_MASTERS-1:0]      m_rty_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic [2:0]                  s_cti_o,
    output logic [1:0]                  s_bte_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    input  logic                        s_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_t    state, state_nxt;
    logic [IW-1:0] g_idx, g_idx_nxt;
    logic [IW-1:0] last_owner, last_owner_nxt;
    logic          granted;
    logic          resp;
    logic          abort;

    assign granted = (state == GRANT);
    assign resp    = s_ack_i | s_err_i | s_rty_i;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .active (granted),
        .stb    (granted & m_stb_i[g_idx]),
        .resp   (resp),
        .abort  (abort)
    );

    // State, owner and rotation pointer registers; last_owner starts at the
    // top index so master 0 wins the first arbitration.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state      <= IDLE;
            g_idx      <= '0;
            last_owner <= IW'(NUM_MASTERS - 1);
        end else begin
            state      <= state_nxt;
            g_idx      <= g_idx_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next-state logic: pick in IDLE, release when the owner drops cyc.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        g_idx_nxt      = g_idx;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    g_idx_nxt = IW'(rr_pick(MAX_MASTERS'(m_cyc_i),
                                            3'(last_owner), NUM_MASTERS));
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!m_cyc_i[g_idx]) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = g_idx;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request mux to the slave and response routing back to the owner only.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        grant_o = '0;
        m_dat_o = s_dat_i;
        if (granted) begin
            s_adr_o        = m_adr_i[g_idx*AW +: AW];
            s_dat_o        = m_dat_i[g_idx*DW +: DW];
            s_sel_o        = m_sel_i[g_idx*SW +: SW];
            s_we_o         = m_we_i[g_idx];
            s_cyc_o        = m_cyc_i[g_idx];
            s_stb_o        = m_stb_i[g_idx] & ~abort;
            s_cti_o        = m_cti_i[g_idx*3 +: 3];
            s_bte_o        = m_bte_i[g_idx*2 +: 2];
            grant_o[g_idx] = 1'b1;
            m_ack_o[g_idx] = s_ack_i;
            m_err_o[g_idx] = s_err_i | abort;
            m_rty_o[g_idx] = s_rty_i;
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter: single access, full rotation, burst
// hold-off, watchdog abort and ack-wins race, asynchronous reset mid-burst.
module tb_wb_ram_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_n_i;
    logic [NM*AW-1:0]    m_adr_i;
    logic [NM*DW-1:0]    m_dat_i;
    logic [NM*DW/8-1:0]  m_sel_i;
    logic [NM-1:0]       m_we_i;
    logic [NM-1:0]       m_cyc_i;
    logic [NM-1:0]       m_stb_i;
    logic [NM*3-1:0]     m_cti_i;
    logic [NM*2-1:0]     m_bte_i;
    logic [DW-1:0]       m_dat_o;
    logic [NM-1:0]       m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]          s_cti_o;
    logic [1:0]          s_bte_o;
    logic [DW-1:0]       s_dat_i;
    logic                s_ack_i, s_err_i, s_rty_i;
    logic [NM-1:0]       grant_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    int          owners[4];

    wb_ram_arbiter #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TO)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .m_adr_i    (m_adr_i),
        .m_dat_i    (m_dat_i),
        .m_sel_i    (m_sel_i),
        .m_we_i     (m_we_i),
        .m_cyc_i    (m_cyc_i),
        .m_stb_i    (m_stb_i),
        .m_cti_i    (m_cti_i),
        .m_bte_i    (m_bte_i),
        .m_dat_o    (m_dat_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .m_rty_o    (m_rty_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_we_o     (s_we_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_cti_o    (s_cti_o),
        .s_bte_o    (s_bte_o),
        .s_dat_i    (s_dat_i),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i),
        .s_rty_i    (s_rty_i),
        .grant_o    (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    // Read data the bench slave returns for a given address.
    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("comparison %s did not hold", tag);
        end
    endtask

    // Compare broadcast read data against the oldest scoreboard entry.
    task automatic chk_dat(input string tag);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            exp = sb_q.pop_front();
            chk(tag, 64'(m_dat_o), 64'(exp));
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc_i[k]          = cyc;
        m_stb_i[k]          = stb;
        m_adr_i[k*AW +: AW] = adr;
        m_cti_i[k*3 +: 3]   = cti;
    endtask

    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        logic [31:0] adr;
        logic [2:0]  cti;
        owners = '{0, 1, 2, 0};

        wb_rst_n_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '1; m_we_i = '0;
        m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

        // ---- reset state ----
        @(negedge wb_clk_i);
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("rst_s_stb", 64'(s_stb_o), 64'(0));
        chk("rst_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'(0));
        @(posedge wb_clk_i); #1;
        wb_rst_n_i = 1'b1;

        // ---- master 1 single read, ack on 2nd strobe cycle ----
        set_m(1, 1'b1, 1'b1, 32'h0000_0040, CTI_CLASSIC);
        sb_q.push_back(slv_data(32'h0000_0040));
        @(negedge wb_clk_i);
        chk("t1_no_grant_yet", 64'(grant_o), 64'(0));
        chk("t1_no_s_cyc_yet", 64'(s_cyc_o), 64'(0));
        next_cycle();
        @(negedge wb_clk_i);
        chk("t1_grant", 64'(grant_o), 64'(3'b010));
        chk("t1_s_cyc", 64'(s_cyc_o), 64'(1));
        chk("t1_s_stb", 64'(s_stb_o), 64'(1));
        chk("t1_s_adr", 64'(s_adr_o), 64'(32'h40));
        chk("t1_s_sel", 64'(s_sel_o), 64'(4'hF));
        chk("t1_no_ack", 64'(m_ack_o), 64'(0));
        next_cycle();
        s_ack_i = 1'b1;
        s_dat_i = slv_data(32'h0000_0040);
        @(negedge wb_clk_i);
        chk("t1_ack", 64'(m_ack_o), 64'(3'b010));
        chk("t1_no_err", 64'(m_err_o), 64'(0));
        chk_dat("t1_dat");
        next_cycle();
        s_ack_i = 1'b0;
        set_m(1, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        @(negedge wb_clk_i);
        chk("t1_ack_one_cycle", 64'(m_ack_o), 64'(0));
        chk("t1_grant_held", 64'(grant_o), 64'(3'b010));
        next_cycle();
        @(negedge wb_clk_i);
        chk("t1_s_cyc_low", 64'(s_cyc_o), 64'(0));
        chk("t1_released", 64'(grant_o), 64'(0));

        // ---- all three masters request: strict rotation from reset ----
        wb_rst_n_i = 1'b0;
        next_cycle();
        wb_rst_n_i = 1'b1;
        for (int k = 0; k < NM; k++) set_m(k, 1'b1, 1'b1, 32'h100 + 32'(k * 16), CTI_CLASSIC);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            chk($sformatf("t2_idle_%0d", i), 64'(grant_o), 64'(0));
            next_cycle();
            adr = 32'h100 + 32'(owners[i] * 16);
            s_ack_i = 1'b1;
            s_dat_i = slv_data(adr);
            sb_q.push_back(slv_data(adr));
            @(negedge wb_clk_i);
            chk($sformatf("t2_grant_%0d", i), 64'(grant_o), 64'(1 << owners[i]));
            chk($sformatf("t2_ack_%0d", i), 64'(m_ack_o), 64'(1 << owners[i]));
            chk($sformatf("t2_adr_%0d", i), 64'(s_adr_o), 64'(adr));
            chk_dat($sformatf("t2_dat_%0d", i));
            next_cycle();
            s_ack_i = 1'b0;
            if (i == 3) begin
                for (int k = 0; k < NM; k++) set_m(k, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
            end else begin
                set_m(owners[i], 1'b0, 1'b0, adr, CTI_CLASSIC);
            end
            @(negedge wb_clk_i);
            chk($sformatf("t2_s_cyc_drop_%0d", i), 64'(s_cyc_o), 64'(0));
            next_cycle();
            if (i != 3) set_m(owners[i], 1'b1, 1'b1, adr, CTI_CLASSIC);
        end

        // ---- master 0 8-beat INCR burst while master 2 waits ----
        set_m(0, 1'b1, 1'b1, 32'h200, CTI_INCR);
        for (int b = 0; b < 8; b++) sb_q.push_back(slv_data(32'h200 + 32'(b * 4)));
        @(negedge wb_clk_i);
        chk("t3_idle", 64'(grant_o), 64'(0));
        next_cycle();
        set_m(2, 1'b1, 1'b1, 32'h300, CTI_CLASSIC);
        for (int b = 0; b < 8; b++) begin
            adr = 32'h200 + 32'(b * 4);
            cti = (b == 7) ? CTI_EOB : CTI_INCR;
            set_m(0, 1'b1, 1'b1, adr, cti);
            s_ack_i = 1'b1;
            s_dat_i = slv_data(adr);
            @(negedge wb_clk_i);
            chk($sformatf("t3_grant_b%0d", b), 64'(grant_o), 64'(3'b001));
            chk($sformatf("t3_ack_b%0d", b), 64'(m_ack_o), 64'(3'b001));
            chk($sformatf("t3_cti_b%0d", b), 64'(s_cti_o), 64'(cti));
            chk($sformatf("t3_adr_b%0d", b), 64'(s_adr_o), 64'(adr));
            chk_dat($sformatf("t3_dat_b%0d", b));
            next_cycle();
        end
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        @(negedge wb_clk_i);
        chk("t3_hold_after_eob", 64'(grant_o), 64'(3'b001));
        chk("t3_m2_no_resp", 64'({m_ack_o[2], m_err_o[2]}), 64'(0));
        next_cycle();
        @(negedge wb_clk_i);
        chk("t3_gap_idle", 64'(grant_o), 64'(0));
        next_cycle();
        @(negedge wb_clk_i);
        chk("t3_m2_granted", 64'(grant_o), 64'(3'b100));

        // ---- watchdog: slave never answers master 2 ----
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                next_cycle();
                @(negedge wb_clk_i);
            end
            if (c < 4) begin
                chk($sformatf("t4_no_err_c%0d", c), 64'(m_err_o), 64'(0));
                chk($sformatf("t4_stb_c%0d", c), 64'(s_stb_o), 64'(1));
            end else begin
                chk("t4_abort_err", 64'(m_err_o), 64'(3'b100));
                chk("t4_abort_stb_masked", 64'(s_stb_o), 64'(0));
                chk("t4_abort_no_ack", 64'(m_ack_o), 64'(0));
            end
        end
        next_cycle();
        set_m(2, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        @(negedge wb_clk_i);
        chk("t4_count_cleared", 64'(dut.u_wdog.count), 64'(0));
        chk("t4_err_one_cycle", 64'(m_err_o), 64'(0));
        next_cycle();

        // ---- ack on exactly the 4th strobe cycle beats the abort ----
        set_m(2, 1'b1, 1'b1, 32'h340, CTI_CLASSIC);
        m_we_i[2] = 1'b1;
        sb_q.push_back(slv_data(32'h340));
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) next_cycle();
            if (c == 4) begin
                s_ack_i = 1'b1;
                s_dat_i = slv_data(32'h340);
            end
            @(negedge wb_clk_i);
            if (c < 4) begin
                chk($sformatf("t5_wait_c%0d", c), 64'({m_ack_o, m_err_o}), 64'(0));
            end else begin
                chk("t5_ack", 64'(m_ack_o), 64'(3'b100));
                chk("t5_no_err", 64'(m_err_o), 64'(0));
                chk("t5_stb_kept", 64'(s_stb_o), 64'(1));
                chk("t5_we", 64'(s_we_o), 64'(1));
                chk_dat("t5_dat");
            end
        end
        next_cycle();
        s_ack_i = 1'b0;
        m_we_i[2] = 1'b0;
        set_m(2, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
        next_cycle();

        // ---- asynchronous reset in the middle of a master 1 burst ----
        set_m(1, 1'b1, 1'b1, 32'h400, CTI_INCR);
        next_cycle();
        s_ack_i = 1'b1;
        s_dat_i = slv_data(32'h400);
        sb_q.push_back(slv_data(32'h400));
        @(negedge wb_clk_i);
        chk("t6_grant", 64'(grant_o), 64'(3'b010));
        chk("t6_ack_b0", 64'(m_ack_o), 64'(3'b010));
        chk_dat("t6_dat_b0");
        next_cycle();
        set_m(1, 1'b1, 1'b1, 32'h404, CTI_INCR);
        s_dat_i = slv_data(32'h404);
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        chk("t6_async_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("t6_async_s_stb", 64'(s_stb_o), 64'(0));
        chk("t6_async_grant", 64'(grant_o), 64'(0));
        chk("t6_async_no_resp", 64'({m_ack_o, m_err_o, m_rty_o}), 64'(0));
        s_ack_i = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'h500, CTI_CLASSIC);
        @(posedge wb_clk_i); #1;
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        chk("t6_idle_after_rst", 64'(grant_o), 64'(0));
        next_cycle();
        @(negedge wb_clk_i);
        chk("t6_first_grant_m0", 64'(grant_o), 64'(3'b001));
        chk("t6_first_adr", 64'(s_adr_o), 64'(32'h500));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
